// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings and field layouts for the ALU issue stage.
// Holds opsel/op encodings, the instruction field layout and the pipeline tag.
package alu_pkg;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 8;
    localparam int RADDR_W  = 3;

    typedef enum logic [2:0] {
        SHIFT_REG   = 3'b000,
        ARITH_LOGIC = 3'b001,
        MEM_WRITE   = 3'b100,
        MEM_READ    = 3'b101
    } opsel_e;

    typedef enum logic [2:0] {
        ADD  = 3'b000,
        HADD = 3'b001,
        SUB  = 3'b010,
        NOT  = 3'b011,
        AND  = 3'b100,
        OR   = 3'b101,
        XOR  = 3'b110,
        LHG  = 3'b111
    } arith_op_e;

    typedef enum logic [2:0] {
        LOADBYTE   = 3'b000,
        LOADHALF   = 3'b001,
        LOADWORD   = 3'b011,
        LOADBYTEU  = 3'b100,
        LOADHALFU  = 3'b101
    } load_op_e;

    typedef struct packed {
        logic [15:0] imm;
        logic [2:0]  rs2;
        logic [2:0]  rs1;
        logic [2:0]  rd;
        logic        imm_sel;
        logic [2:0]  opsel;
        logic [2:0]  op;
    } instr_t;

    // Pipeline tag: what an in-flight instruction will do at writeback.
    typedef struct packed {
        logic       valid;
        logic       wr;
        logic [2:0] rd;
        logic       is_arith;
    } tag_t;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NUM_REGS x DATA_W register file, 2 async reads, 1 sync write.
// Ports: clock, reset (async active-low clear), we/waddr/wdata write port,
//        raddr1/raddr2 -> rdata1/rdata2 combinational read ports.
// Writes to r0 are dropped so r0 always reads 0.
module alu_regfile #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int RADDR_W  = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               we,
    input  logic [RADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [RADDR_W-1:0] raddr1,
    input  logic [RADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0]  rdata1,
    output logic [DATA_W-1:0]  rdata2
);
    logic [DATA_W-1:0] mem [NUM_REGS];

    always_ff @(posedge clock or negedge reset)
        if (!reset)
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        else if (we && waddr != '0)
            mem[waddr] <= wdata;

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand fetch/issue into arith_alu with writeback folded in.
// Ports: clock, reset (async active-low); instr_valid/instr/instr_ready upstream
//        handshake; mem_rdata load data; aluout_arith/carry from the ALU;
//        aluin1/aluin2/alu_opselect/alu_operation/enable to the ALU;
//        carry_flag last committed arithmetic carry; retire writeback pulse.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int RADDR_W  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] aluout_arith,
    input  logic              carry,
    output logic [DATA_W-1:0] aluin1,
    output logic [DATA_W-1:0] aluin2,
    output logic [2:0]        alu_opselect,
    output logic [2:0]        alu_operation,
    output logic              enable,
    output logic              carry_flag,
    output logic              retire
);
    instr_t            ins;
    tag_t              s1, s2;
    logic [DATA_W-1:0] rf1, rf2, op1, op2, imm_ext;
    logic              is_load, is_arith, wr, dep, issue;

    assign ins      = instr;
    assign is_load  = ins.opsel == MEM_READ;
    assign is_arith = ins.opsel == ARITH_LOGIC;
    assign wr       = (is_load || is_arith) && ins.rd != '0;
    assign imm_ext  = {{(DATA_W-16){ins.imm[15]}}, ins.imm};

    // s1's result is still inside the ALU, so a reader must wait one cycle;
    // loads and immediate forms never look at rs2.
    assign dep = s1.valid && s1.wr && s1.rd != '0 &&
                 (s1.rd == ins.rs1 || (s1.rd == ins.rs2 && !ins.imm_sel && !is_load));
    assign instr_ready = !(instr_valid && dep);
    assign issue       = instr_valid && instr_ready;

    // s2's result sits on aluout_arith and is newer than the regfile copy.
    assign op1 = ins.rs1 == '0 ? '0 :
                 (s2.valid && s2.wr && s2.rd == ins.rs1) ? aluout_arith : rf1;
    assign op2 = is_load ? mem_rdata :
                 ins.imm_sel ? imm_ext :
                 ins.rs2 == '0 ? '0 :
                 (s2.valid && s2.wr && s2.rd == ins.rs2) ? aluout_arith : rf2;

    alu_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .RADDR_W(RADDR_W)) u_regfile (
        .clock  (clock),
        .reset  (reset),
        .we     (s2.valid && s2.wr),
        .waddr  (s2.rd),
        .wdata  (aluout_arith),
        .raddr1 (ins.rs1),
        .raddr2 (ins.rs2),
        .rdata1 (rf1),
        .rdata2 (rf2)
    );

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            aluin1        <= '0;
            aluin2        <= '0;
            alu_opselect  <= '0;
            alu_operation <= '0;
            enable        <= 1'b0;
            carry_flag    <= 1'b0;
            retire        <= 1'b0;
            s1            <= '0;
            s2            <= '0;
        end else begin
            enable <= issue;
            if (issue) begin
                aluin1        <= op1;
                aluin2        <= op2;
                alu_opselect  <= ins.opsel;
                alu_operation <= ins.op;
            end
            s1     <= issue ? tag_t'{1'b1, wr, ins.rd, is_arith} : '0;
            s2     <= s1;
            retire <= s2.valid;
            if (s2.valid && s2.is_arith) carry_flag <= carry;
        end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vectors with a scoreboard on the ALU issue port.
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [31:0] mem_rdata;
    logic [31:0] aluout_arith;
    logic        carry;
    logic [31:0] aluin1, aluin2;
    logic [2:0]  alu_opselect, alu_operation;
    logic        enable, carry_flag, retire;

    int total = 0;
    int bad   = 0;
    int rcnt  = 0;
    int snap;

    typedef struct {
        logic [2:0]  opsel;
        logic [2:0]  op;
        logic [31:0] a1;
        logic [31:0] a2;
    } exp_t;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    alu_issue_stage dut (
        .clock         (clock),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .mem_rdata     (mem_rdata),
        .aluout_arith  (aluout_arith),
        .carry         (carry),
        .aluin1        (aluin1),
        .aluin2        (aluin2),
        .alu_opselect  (alu_opselect),
        .alu_operation (alu_operation),
        .enable        (enable),
        .carry_flag    (carry_flag),
        .retire        (retire)
    );

    // Behavioural arith_alu: registers its result on enable, holds otherwise.
    always @(posedge clock or negedge reset) begin
        logic [32:0] sum;
        if (!reset) begin
            aluout_arith <= '0;
            carry        <= 1'b0;
        end else if (enable) begin
            sum = {1'b0, aluin1} + {1'b0, aluin2};
            if (alu_opselect == ARITH_LOGIC) begin
                if (alu_operation == ADD) begin
                    aluout_arith <= sum[31:0];
                    carry        <= sum[32];
                end else if (alu_operation == AND) begin
                    aluout_arith <= aluin1 & aluin2;
                    carry        <= 1'b0;
                end else begin
                    aluout_arith <= aluin1 | aluin2;
                    carry        <= 1'b0;
                end
            end else if (alu_opselect == MEM_READ) begin
                aluout_arith <= alu_operation == LOADBYTE ? {{24{aluin2[7]}}, aluin2[7:0]} : aluin2;
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // Monitor: every enable pulse must match the oldest expected issue.
    always @(negedge clock) begin
        exp_t e;
        if (reset && enable) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL issue: enable with no expected entry, aluin1=%h aluin2=%h", aluin1, aluin2);
            end else begin
                e = exp_q.pop_front();
                if ({alu_opselect, alu_operation, aluin1, aluin2} !== {e.opsel, e.op, e.a1, e.a2}) begin
                    bad++;
                    $display("FAIL issue: got sel=%0d op=%0d a1=%h a2=%h expected sel=%0d op=%0d a1=%h a2=%h",
                             alu_opselect, alu_operation, aluin1, aluin2, e.opsel, e.op, e.a1, e.a2);
                end
            end
        end
    end

    always @(negedge clock) if (retire) rcnt++;

    function automatic logic [31:0] mk(input logic [2:0] opsel, input logic [2:0] op,
                                       input logic [2:0] rd, input logic [2:0] rs1,
                                       input logic [2:0] rs2, input logic isel,
                                       input logic [15:0] imm);
        return {imm, rs2, rs1, rd, isel, opsel, op};
    endfunction

    // Called at a negedge; returns at the negedge after the issue edge.
    task automatic send(input logic [31:0] i, input logic [31:0] m,
                        input logic [31:0] e1, input logic [31:0] e2, input int exp_st);
        int st = 0;
        exp_t e;
        instr_valid = 1'b1;
        instr       = i;
        mem_rdata   = m;
        #1;
        while (!instr_ready && st < 8) begin
            @(negedge clock);
            #1;
            st++;
            chk("bubble enable", {31'b0, enable}, 32'd0);
        end
        chk("stall cycles", st, exp_st);
        e.opsel = i[5:3];
        e.op    = i[2:0];
        e.a1    = e1;
        e.a2    = e2;
        exp_q.push_back(e);
        @(negedge clock);
        instr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk_reset_outs();
        chk("rst enable", {31'b0, enable}, 32'd0);
        chk("rst aluin1", aluin1, 32'd0);
        chk("rst aluin2", aluin2, 32'd0);
        chk("rst retire", {31'b0, retire}, 32'd0);
        chk("rst carry_flag", {31'b0, carry_flag}, 32'd0);
        chk("rst instr_ready", {31'b0, instr_ready}, 32'd1);
        chk("rst opsel/op", {26'b0, alu_opselect, alu_operation}, 32'd0);
    endtask

    initial begin
        reset       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        mem_rdata   = '0;
        idle(2);
        chk_reset_outs();
        reset = 1'b1;
        idle(1);

        // Immediate adds, second one sign-extended.
        snap = rcnt;
        send(mk(ARITH_LOGIC, ADD, 1, 0, 0, 1, 16'h0005), 0, 32'h0, 32'h5, 0);
        send(mk(ARITH_LOGIC, ADD, 2, 0, 0, 1, 16'hFFFF), 0, 32'h0, 32'hFFFFFFFF, 0);
        idle(3);
        chk("retire twice", rcnt - snap, 2);
        send(mk(MEM_WRITE, 0, 0, 1, 2, 0, 0), 0, 32'h5, 32'hFFFFFFFF, 0);

        // Back-to-back dependency on both sources: one bubble, then forward.
        idle(3);
        send(mk(ARITH_LOGIC, ADD, 1, 0, 0, 1, 16'h0005), 0, 32'h0, 32'h5, 0);
        send(mk(ARITH_LOGIC, ADD, 2, 1, 1, 0, 0), 0, 32'h5, 32'h5, 1);
        idle(3);
        send(mk(MEM_WRITE, 0, 0, 2, 2, 0, 0), 0, 32'hA, 32'hA, 0);

        // Carry out of a dependent add, then cleared by AND.
        idle(3);
        send(mk(ARITH_LOGIC, ADD, 1, 0, 0, 1, 16'hFFFF), 0, 32'h0, 32'hFFFFFFFF, 0);
        send(mk(ARITH_LOGIC, ADD, 3, 1, 0, 1, 16'h0001), 0, 32'hFFFFFFFF, 32'h1, 1);
        idle(3);
        chk("carry_flag set", {31'b0, carry_flag}, 32'd1);
        send(mk(ARITH_LOGIC, AND, 5, 1, 0, 1, 16'h00FF), 0, 32'hFFFFFFFF, 32'hFF, 0);
        idle(3);
        chk("carry_flag clear", {31'b0, carry_flag}, 32'd0);
        send(mk(MEM_WRITE, 0, 0, 3, 5, 0, 0), 0, 32'h0, 32'hFF, 0);

        // Loads: second load names r4 in rs2 only, which must not stall.
        idle(3);
        send(mk(MEM_READ, LOADBYTE, 4, 0, 0, 0, 0), 32'h000000F0, 32'h0, 32'hF0, 0);
        send(mk(MEM_READ, LOADBYTE, 6, 0, 4, 0, 0), 32'h0000007F, 32'h0, 32'h7F, 0);
        idle(3);
        send(mk(MEM_WRITE, 0, 0, 4, 6, 0, 0), 0, 32'hFFFFFFF0, 32'h7F, 0);

        // rd=r0 and MEM_WRITE never write or stall; retire still pulses.
        idle(3);
        snap = rcnt;
        send(mk(ARITH_LOGIC, ADD, 0, 0, 0, 1, 16'h0007), 0, 32'h0, 32'h7, 0);
        send(mk(MEM_WRITE, 0, 0, 0, 0, 0, 0), 0, 32'h0, 32'h0, 0);
        send(mk(MEM_WRITE, 0, 2, 0, 0, 0, 0), 0, 32'h0, 32'h0, 0);
        send(mk(MEM_WRITE, 0, 0, 2, 2, 0, 0), 0, 32'hA, 32'hA, 0);
        idle(3);
        chk("retire count r0/store", rcnt - snap, 4);

        // Read in the same cycle as the writeback sees the new value.
        send(mk(ARITH_LOGIC, ADD, 7, 0, 0, 1, 16'h0003), 0, 32'h0, 32'h3, 0);
        send(mk(MEM_WRITE, 0, 0, 0, 0, 0, 0), 0, 32'h0, 32'h0, 0);
        send(mk(MEM_WRITE, 0, 0, 7, 7, 0, 0), 0, 32'h3, 32'h3, 0);

        // Reset while an add is in flight: nothing is written back.
        idle(3);
        send(mk(ARITH_LOGIC, ADD, 3, 0, 0, 1, 16'h0009), 0, 32'h0, 32'h9, 0);
        snap = rcnt;
        #2 reset = 1'b0;
        #1 chk_reset_outs();
        idle(1);
        reset = 1'b1;
        idle(3);
        chk("no retire after reset", rcnt - snap, 0);
        send(mk(MEM_WRITE, 0, 0, 3, 1, 0, 0), 0, 32'h0, 32'h0, 0);

        idle(3);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
